// File: rtl/cache_memory_arbiter.sv
// I/D-cache to main-memory word-bus arbiter: burst-locked grant, 1-cycle registered arbitration, then zero-latency pass-through.
// Backpressure: bus_ready low stretches the grant, the losing cache waits in place; ARBITER_ROUND_ROBIN_EN selects round-robin ties.
module cache_memory_arbiter #(
  parameter int BURST_WORDS = 4,
  parameter int COUNT_BITS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_memory_address,
  input  logic        instruction_memory_request,
  output logic [31:0] instruction_memory_read_data,
  output logic        instruction_memory_ready,
  input  logic [31:0] data_memory_address,
  input  logic        data_memory_request,
  input  logic        data_memory_write_enable,
  input  logic [31:0] data_memory_write_data,
  output logic [31:0] data_memory_read_data,
  output logic        data_memory_ready,
  output logic [31:0] bus_address,
  output logic        bus_request,
  output logic        bus_write_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(BURST_WORDS);

  state_t                state, state_next;
  logic [COUNT_BITS-1:0] count, count_next;
  logic [COUNT_BITS-1:0] count_inc;
  logic                  d_wins_tie;

  assign count_inc = count + COUNT_BITS'(1);

`ifdef ARBITER_ROUND_ROBIN_EN
  // Reset to 1 so the I-cache wins the first tie after reset.
  logic last_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b1;
    end else if (state == IDLE && state_next != IDLE) begin
      last_grant_d <= (state_next == GRANT_D);
    end
  end

  assign d_wins_tie = !last_grant_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next                   = state;
    count_next                   = count;
    bus_address                  = '0;
    bus_request                  = 1'b0;
    bus_write_enable             = 1'b0;
    bus_write_data               = '0;
    instruction_memory_ready     = 1'b0;
    instruction_memory_read_data = '0;
    data_memory_ready            = 1'b0;
    data_memory_read_data        = '0;

    case (state)
      IDLE: begin
        // Counter is cleared here so every grant starts from zero.
        count_next = '0;
        if (instruction_memory_request && data_memory_request) begin
          state_next = d_wins_tie ? GRANT_D : GRANT_I;
        end else if (instruction_memory_request) begin
          state_next = GRANT_I;
        end else if (data_memory_request) begin
          state_next = GRANT_D;
        end
      end

      GRANT_I: begin
        bus_address                  = instruction_memory_address;
        bus_request                  = instruction_memory_request;
        instruction_memory_ready     = bus_ready && instruction_memory_request;
        instruction_memory_read_data = bus_read_data;
        if (!instruction_memory_request) begin
          state_next = IDLE;
          count_next = '0;
        end else if (bus_ready) begin
          count_next = count_inc;
          if (count_inc == LAST_COUNT) state_next = IDLE;
        end
      end

      GRANT_D: begin
        bus_address           = data_memory_address;
        bus_request           = data_memory_request;
        bus_write_enable      = data_memory_write_enable;
        bus_write_data        = data_memory_write_data;
        data_memory_ready     = bus_ready && data_memory_request;
        data_memory_read_data = bus_read_data;
        if (!data_memory_request) begin
          state_next = IDLE;
          count_next = '0;
        end else if (bus_ready) begin
          count_next = count_inc;
          if (count_inc == LAST_COUNT) state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: doc/cache_memory_arbiter.md
# cache_memory_arbiter

Two-master, one-slave word-bus arbiter between the L1 instruction cache, the L1 data cache and the single 32-bit main-memory port. Grants the bus to one cache at a time and holds the grant for a full line refill, so 4-word bursts are never interleaved. Routes address, write data and request to memory, and returns read data and ready to the granted cache only.

## Interface
- `BURST_WORDS`, default 4: word handshakes per grant. This is the line size in words; minimum 1.
- `COUNT_BITS`, default 3: burst counter width. Must satisfy 2^COUNT_BITS > BURST_WORDS.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instruction_memory_address` in 32: I-cache word address.
- `instruction_memory_request` in 1: I-cache request, held high for the whole refill.
- `instruction_memory_read_data` out 32: read data to the I-cache.
- `instruction_memory_ready` out 1: one I-cache word handshake completed.
- `data_memory_address` in 32: D-cache word address.
- `data_memory_request` in 1: D-cache request.
- `data_memory_write_enable` in 1: D-cache write (1) or read (0).
- `data_memory_write_data` in 32: D-cache write data.
- `data_memory_read_data` out 32: read data to the D-cache.
- `data_memory_ready` out 1: one D-cache word handshake completed.
- `bus_address` out 32: memory address.
- `bus_request` out 1: memory request.
- `bus_write_enable` out 1: memory write strobe.
- `bus_write_data` out 32: memory write data.
- `bus_read_data` in 32: memory read data.
- `bus_ready` in 1: memory word completion, valid only while `bus_request` is high.

## Operation
- The FSM has three states: `IDLE`, `GRANT_I`, `GRANT_D`.
- **`IDLE`**
  - All `bus_*` outputs are 0.
  - Both `*_ready` outputs are 0.
  - Both `*_read_data` outputs are 0.
  - The requesters present this cycle are sampled.
  - Neither requests: stay in `IDLE`.
  - Exactly one requests: go to that requester's grant state.
  - Both request: the winner is chosen by the arbitration policy (see Configuration).
- **`GRANT_I`**
  - `bus_address` = `instruction_memory_address`.
  - `bus_request` = `instruction_memory_request`.
  - `bus_write_enable` = 0.
  - `bus_write_data` = 0.
  - `instruction_memory_ready` = `bus_ready`.
  - `instruction_memory_read_data` = `bus_read_data`.
  - The D-cache sees ready 0 and read data 0.
- **`GRANT_D`**
  - All four `bus_*` outputs are driven from the D-cache port.
  - `data_memory_ready` = `bus_ready`.
  - `data_memory_read_data` = `bus_read_data`.
  - The I-cache sees ready 0 and read data 0.
- **Burst counter**
  - Cleared on entry to any grant state.
  - Incremented on every cycle with `bus_request && bus_ready`.
- **Grant release**
  - On the handshake that makes the count equal `BURST_WORDS`: next state is `IDLE`.
  - If the granted requester deasserts its request during a grant: next state is `IDLE` and the counter clears. A partial burst is legal.
- A request from the non-granted cache is held pending. It is never dropped, and it is arbitrated at the next `IDLE`.
- `bus_ready` while `bus_request` = 0 is ignored.

## Timing
- The grant is registered.
- A request seen in `IDLE` at edge N gets `bus_request` during cycle N+1. This adds 1 cycle of arbitration latency per burst.
- In a grant state, request/address to bus and ready/data back are combinational pass-through, with zero added latency.
- Between grants there is at least one `IDLE` cycle, so back-to-back bursts cost 1 bubble.
- A 4-word burst with single-cycle memory occupies 1 `IDLE` cycle plus 4 grant cycles.
- Memory wait states (`bus_ready` low) simply extend the grant. There is no timeout.
- **Reset** (async, any time, including mid-burst):
  - state = `IDLE`, counter = 0, priority pointer = I-cache first.
  - All outputs are 0 immediately.
  - A burst in flight is abandoned, and the requester re-arbitrates after `rst_n` rises.
- A request and `bus_ready` arriving in the same cycle as `IDLE` produce no handshake in that cycle.

## Configuration
- Macro: `ARBITER_ROUND_ROBIN_EN`.
- **Defined**
  - One-bit pointer `last_grant_d`, set at each grant. It is 1 when the last grant went to the D-cache.
  - On a tie, the requester not served last wins.
  - Reset value 1, so the I-cache wins the first tie.
- **Undefined**
  - Fixed priority: the D-cache always wins a tie.
  - No pointer register exists.

## Test plan
- **Single I-cache refill.** I-cache requests addresses 0x100/104/108/10C, memory ready every cycle with data 0xA0..0xA3.
  - Expect `bus_request` from cycle 1.
  - Expect 4 `instruction_memory_ready` pulses with matching data, then `IDLE`.
  - Expect `data_memory_ready` to stay 0 throughout.
- **Tie, fixed priority (macro undefined).** Both caches request in the same cycle.
  - Expect `GRANT_D` for 4 words (D write 0xDEADBEEF to 0x200 visible on the bus with `bus_write_enable`=1).
  - Then 1 `IDLE` cycle, then `GRANT_I`.
- **Tie, round robin (macro defined).** Both caches request continuously for 3 bursts.
  - Expect grants in the order I, D, I.
- **Wait states.** Memory inserts 2 low-ready cycles before each word.
  - Expect the grant held for 12 cycles.
  - Expect the counter to reach 4 and exactly 4 ready pulses.
- **Early drop.** The D-cache deasserts its request after 2 handshakes.
  - Expect `IDLE` on the next cycle.
  - Expect a pending I-cache request granted the cycle after that, with a fresh count of 0.
- **Reset mid-burst.** Assert `rst_n`=0 after word 1 of an I-cache burst.
  - Expect all outputs 0 asynchronously.
  - After release, expect the I-cache re-granted from count 0.
